// File: rtl/spi_mem_ctrl_if.sv
// Host-side word-transaction bus for spi_mem_ctrl.
//   req   : start one 16-bit transaction (master -> controller)
//   we    : 1 = write, 0 = read, sampled with req
//   addr  : 24-bit byte address, sampled with req
//   wdata : 16-bit write word, sampled with req
//   rdata : last word read from the serial RAM (controller -> master)
//   busy  : controller is not idle
//   done  : one-cycle completion pulse
interface spi_mem_ctrl_if;
  logic        req;
  logic        we;
  logic [23:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        busy;
  logic        done;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  rdata,
    input  busy,
    input  done
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output rdata,
    output busy,
    output done
  );
endinterface

// File: rtl/spi_mem_ctrl.sv
// SPI serial-RAM word controller.
// Runs one 48-bit mode-0 SPI frame per accepted request:
//   8-bit opcode, 24-bit address, 16 data bits (MSB first, big-endian word).
// Each SPI bit spans two clk cycles (spi_clk low, then high); spi_mosi moves
// only on the edge that drives spi_clk low, and spi_miso is sampled there too.
// After the frame, chip select stays low for two cycles before the next frame.
// Ports:
//   clk, rst_n  : system clock (rising edge), asynchronous active-low reset
//   bus         : host bus (req/we/addr/wdata in, rdata/busy/done out)
//   spi_select  : chip select, active high
//   spi_clk     : SPI clock, idles low
//   spi_mosi    : serial data to the RAM
//   spi_miso    : serial data from the RAM
module spi_mem_ctrl #(
  parameter logic [7:0] CMD_READ  = 8'h03,
  parameter logic [7:0] CMD_WRITE = 8'h02
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_mem_ctrl_if.slave        bus,
  output logic                 spi_select,
  output logic                 spi_clk,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_e;

  // Bit counter values at the sample edge of the last bit of each field.
  localparam logic [5:0] LAST_CMD_BIT  = 6'd7;
  localparam logic [5:0] LAST_ADDR_BIT = 6'd31;
  localparam logic [5:0] LAST_DATA_BIT = 6'd47;
  localparam logic [5:0] GAP_LAST      = 6'd1;

  // Control state (reset)
  state_e      state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic        sel_q, sel_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        done_q, done_d;
  logic [15:0] rdata_q, rdata_d;

  // Datapath state (no reset; always loaded before use)
  logic        we_q, we_d;
  logic [46:0] tx_sr_q, tx_sr_d;
  logic [15:0] rx_sr_q, rx_sr_d;

  logic        accept;
  logic [7:0]  opcode;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sel_d     = sel_q;
    sclk_d    = 1'b0;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    rdata_d   = rdata_q;
    we_d      = we_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    accept    = 1'b0;
    opcode    = bus.we ? CMD_WRITE : CMD_READ;

    case (state_q)
      ST_IDLE: begin
        accept = bus.req;
      end

      ST_CMD, ST_ADDR, ST_DATA: begin
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          // spi_clk falls on this edge: sample miso, advance mosi.
          sclk_d    = 1'b0;
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (state_q == ST_DATA) begin
            rx_sr_d = {rx_sr_q[14:0], spi_miso};
          end
          if (bit_cnt_q == LAST_DATA_BIT) begin
            state_d   = ST_DONE;
            sel_d     = 1'b0;
            mosi_d    = 1'b0;
            done_d    = 1'b1;
            bit_cnt_d = 6'd0;
            if (!we_q) begin
              rdata_d = {rx_sr_q[14:0], spi_miso};
            end
          end else begin
            mosi_d  = tx_sr_q[46];
            tx_sr_d = {tx_sr_q[45:0], 1'b0};
            if (bit_cnt_q == LAST_CMD_BIT) begin
              state_d = ST_ADDR;
            end else if (bit_cnt_q == LAST_ADDR_BIT) begin
              state_d = ST_DATA;
            end
          end
        end
      end

      ST_DONE: begin
        // Two-cycle deselect gap. The edge that ends the gap is also the
        // earliest acceptance edge, so held requests repeat every 98 cycles.
        if (bit_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          accept  = bus.req;
        end else begin
          bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        sel_d   = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase

    if (accept) begin
      state_d   = ST_CMD;
      we_d      = bus.we;
      bit_cnt_d = 6'd0;
      sel_d     = 1'b1;
      sclk_d    = 1'b0;
      mosi_d    = opcode[7];
      // Remaining 47 frame bits; read frames shift out zeros in DATA.
      tx_sr_d   = {opcode[6:0], bus.addr, (bus.we ? bus.wdata : 16'h0000)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 6'd0;
      sel_q     <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= 16'h0000;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sel_q     <= sel_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    tx_sr_q <= tx_sr_d;
    rx_sr_q <= rx_sr_d;
  end

  assign spi_select = sel_q;
  assign spi_clk    = sclk_q;
  assign spi_mosi   = mosi_q;
  assign bus.rdata  = rdata_q;
  assign bus.done   = done_q;
  assign bus.busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl with a behavioural mode-0 serial RAM.
module tb_spi_mem_ctrl;

  logic clk        = 1'b0;
  logic rst_n      = 1'b0;
  logic spi_select;
  logic spi_clk;
  logic spi_mosi;
  logic spi_miso   = 1'b0;

  int tests = 0;
  int fails = 0;

  spi_mem_ctrl_if bus ();

  spi_mem_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .spi_select (spi_select),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural serial RAM
  logic [7:0]  mem [0:255];
  logic [47:0] frame_sr   = '0;
  logic [47:0] last_frame = '0;
  logic [15:0] rd_word    = '0;
  int          bit_n      = 0;
  int          rise_cnt   = 0;
  int          frames     = 0;

  always @(posedge spi_select) begin
    bit_n    = 0;
    rise_cnt = 0;
    frames++;
    spi_miso = 1'b0;
  end

  always @(posedge spi_clk) begin
    frame_sr = {frame_sr[46:0], spi_mosi};
    bit_n++;
    rise_cnt++;
    if (bit_n == 32 && frame_sr[31:24] == 8'h03)
      rd_word = {mem[frame_sr[7:0]], mem[frame_sr[7:0] + 8'd1]};
    if (bit_n == 48 && frame_sr[47:40] == 8'h02) begin
      mem[frame_sr[23:16]]        = frame_sr[15:8];
      mem[frame_sr[23:16] + 8'd1] = frame_sr[7:0];
    end
  end

  always @(negedge spi_clk) begin
    if (spi_select && bit_n >= 32 && bit_n < 48)
      spi_miso = rd_word[47 - bit_n];
  end

  always @(negedge spi_select) begin
    if (rst_n) begin
      last_frame = frame_sr;
      check("rises_per_frame", 64'(rise_cnt), 64'd48);
    end
  end

  // SPI timing monitor
  int   viol      = 0;
  logic prev_sclk = 1'b0;
  logic prev_mosi = 1'b0;
  always @(negedge clk) begin
    if (prev_sclk == 1'b0 && spi_clk == 1'b1 && spi_mosi !== prev_mosi) viol++;
    if (spi_select == 1'b0 && spi_clk == 1'b1) viol++;
    prev_sclk = spi_clk;
    prev_mosi = spi_mosi;
  end

  // Runs one full transaction and checks its timeline against edge T.
  task automatic run_txn(input bit w, input logic [23:0] a, input logic [15:0] d,
                         input logic [15:0] exp_rdata, input bit release_rst);
    @(negedge clk);
    if (release_rst) rst_n = 1'b1;
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    bus.req = 1'b0;
    check("start_sel", 64'(spi_select), 64'd1);
    check("start_busy", 64'(bus.busy), 64'd1);
    check("start_sclk", 64'(spi_clk), 64'd0);
    check("start_mosi", 64'(spi_mosi), 64'd0);
    repeat (95) @(posedge clk);
    #1;
    check("t95_sel", 64'(spi_select), 64'd1);
    check("t95_sclk", 64'(spi_clk), 64'd1);
    check("t95_done", 64'(bus.done), 64'd0);
    @(posedge clk); #1;
    check("t96_done", 64'(bus.done), 64'd1);
    check("t96_sel", 64'(spi_select), 64'd0);
    check("t96_sclk", 64'(spi_clk), 64'd0);
    check("t96_busy", 64'(bus.busy), 64'd1);
    check("t96_rdata", 64'(bus.rdata), 64'(exp_rdata));
    @(posedge clk); #1;
    check("t97_done", 64'(bus.done), 64'd0);
    check("t97_busy", 64'(bus.busy), 64'd1);
    check("t97_sel", 64'(spi_select), 64'd0);
    @(posedge clk); #1;
    check("t98_busy", 64'(bus.busy), 64'd0);
  endtask

  int base;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hBE;
    mem[8'h11] = 8'hEF;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_sel", 64'(spi_select), 64'd0);
    check("rst_sclk", 64'(spi_clk), 64'd0);
    check("rst_mosi", 64'(spi_mosi), 64'd0);
    check("rst_rdata", 64'(bus.rdata), 64'd0);

    // Read 0x000010 -> BEEF
    run_txn(1'b0, 24'h000010, 16'h0000, 16'hBEEF, 1'b1);
    check("rd_frame", 64'(last_frame), 64'h0300_0010_0000);

    // Write 0x0000FE <- 1234, rdata unchanged
    run_txn(1'b1, 24'h0000FE, 16'h1234, 16'hBEEF, 1'b0);
    check("wr_frame", 64'(last_frame), 64'h0200_00FE_1234);
    check("wr_mem_fe", 64'(mem[8'hFE]), 64'h12);
    check("wr_mem_ff", 64'(mem[8'hFF]), 64'h34);

    // Read back the written word
    run_txn(1'b0, 24'h0000FE, 16'h0000, 16'h1234, 1'b0);
    check("rb_frame", 64'(last_frame), 64'h0300_00FE_0000);

    // req held high: one frame per 98 cycles, no queued extras
    base = frames;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 24'h000010;
    @(posedge clk); #1;
    check("hold_t0_sel", 64'(spi_select), 64'd1);
    repeat (96) @(posedge clk);
    #1;
    check("hold_t96_sel", 64'(spi_select), 64'd0);
    check("hold_t96_done", 64'(bus.done), 64'd1);
    @(posedge clk); #1;
    check("hold_t97_sel", 64'(spi_select), 64'd0);
    check("hold_t97_busy", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    check("hold_t98_sel", 64'(spi_select), 64'd1);
    check("hold_t98_done", 64'(bus.done), 64'd0);
    repeat (98) @(posedge clk);
    #1;
    check("hold_t196_sel", 64'(spi_select), 64'd1);
    bus.req = 1'b0;
    repeat (98) @(posedge clk);
    #1;
    check("hold_t294_busy", 64'(bus.busy), 64'd0);
    check("hold_t294_sel", 64'(spi_select), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    check("hold_frames", 64'(frames - base), 64'd3);
    check("hold_rdata", 64'(bus.rdata), 64'hBEEF);

    // Reset in the middle of a frame
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 24'h0000FE;
    @(posedge clk); #1;
    bus.req = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("mid_pre_sel", 64'(spi_select), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_sel", 64'(spi_select), 64'd0);
    check("mid_sclk", 64'(spi_clk), 64'd0);
    check("mid_busy", 64'(bus.busy), 64'd0);
    check("mid_done", 64'(bus.done), 64'd0);
    check("mid_rdata", 64'(bus.rdata), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_hold_sel", 64'(spi_select), 64'd0);
    check("mid_hold_done", 64'(bus.done), 64'd0);

    // Request on the first edge after reset release
    run_txn(1'b0, 24'h000010, 16'h0000, 16'hBEEF, 1'b1);
    check("post_rst_frame", 64'(last_frame), 64'h0300_0010_0000);

    repeat (4) @(posedge clk);
    #1;
    check("timing_viol", 64'(viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
